// File: rtl/full_adder_reg.sv
// full_adder_reg: registered WIDTH-bit ripple-carry adder built from per-bit
// full-adder cells. {cout,sum} = a + b + cin, captured one cycle after in_valid.
// Optional feature macro: FULL_ADDER_OVF_EN adds the registered signed-overflow
// output ovf (c[WIDTH] ^ c[WIDTH-1]); without it the port and register are absent.
//
// Handshake: in_valid qualifies a/b/cin for exactly the cycle it is high; there is
// no ready, every valid cycle is accepted and produces a one-cycle out_valid pulse
// on the following edge. Operand values are ignored while in_valid is low.
module full_adder_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] s;
    logic             carry;
`ifdef FULL_ADDER_OVF_EN
    logic             carry_into_msb;
`endif

    // Ripple chain: each loop iteration is one full-adder cell, carry flows bit 0 upward.
    always_comb begin
        s     = '0;
        carry = cin;
`ifdef FULL_ADDER_OVF_EN
        carry_into_msb = cin;
`endif
        for (int i = 0; i < WIDTH; i++) begin
`ifdef FULL_ADDER_OVF_EN
            carry_into_msb = carry;
`endif
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
    end

    // Valid flag follows in_valid every edge; cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Result register loads only on accepted inputs and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (in_valid) begin
            sum  <= s;
            cout <= carry;
        end
    end

`ifdef FULL_ADDER_OVF_EN
    // Two's-complement overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= carry ^ carry_into_msb;
        end
    end
`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// tb_full_adder_reg: three instances (WIDTH=1, 8, 16) share clock and reset.
// Expected {ovf,cout,sum} words are pushed when a valid input is driven and
// popped when the corresponding out_valid cycle is sampled.
module tb_full_adder_reg;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        iv1, c1, ov1, co1;
    logic [0:0]  a1, b1, s1;
    logic        iv8, c8, ov8, co8;
    logic [7:0]  a8, b8, s8;
    logic        iv16, c16, ov16, co16;
    logic [15:0] a16, b16, s16;
    logic        of1, of8, of16;

    full_adder_reg #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ov1), .sum(s1), .cout(co1)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of1)
`endif
    );

    full_adder_reg #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .cin(c8),
        .out_valid(ov8), .sum(s8), .cout(co8)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of8)
`endif
    );

    full_adder_reg #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .a(a16), .b(b16), .cin(c16),
        .out_valid(ov16), .sum(s16), .cout(co16)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of16)
`endif
    );

`ifndef FULL_ADDER_OVF_EN
    assign of1  = 1'b0;
    assign of8  = 1'b0;
    assign of16 = 1'b0;
`endif

    // ---------------- scoreboard ----------------
    // Entry layout: {ovf, cout, sum}
    logic [2:0]  exp1_q[$];
    logic [9:0]  exp8_q[$];
    logic [17:0] exp16_q[$];
    logic [2:0]  last1;
    logic [9:0]  last8;
    logic [17:0] last16;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ovf_of(input logic ma, input logic mb, input logic ms);
        return (ma == mb) && (ms != ma);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drv1(input logic v, input logic aa, input logic bb, input logic ci);
        logic [1:0] full;
        iv1 = v;
        if (v) begin
            a1 = aa; b1 = bb; c1 = ci;
            full = {1'b0, aa} + {1'b0, bb} + {1'b0, ci};
            exp1_q.push_back({ovf_of(aa, bb, full[0]), full});
        end else begin
            a1 = 'x; b1 = 'x; c1 = 'x;
        end
    endtask

    task automatic drv8(input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic ci);
        logic [8:0] full;
        iv8 = v;
        if (v) begin
            a8 = aa; b8 = bb; c8 = ci;
            full = {1'b0, aa} + {1'b0, bb} + {8'b0, ci};
            exp8_q.push_back({ovf_of(aa[7], bb[7], full[7]), full});
        end else begin
            a8 = 'x; b8 = 'x; c8 = 'x;
        end
    endtask

    task automatic drv16(input logic v, input logic [15:0] aa, input logic [15:0] bb, input logic ci);
        logic [16:0] full;
        iv16 = v;
        if (v) begin
            a16 = aa; b16 = bb; c16 = ci;
            full = {1'b0, aa} + {1'b0, bb} + {16'b0, ci};
            exp16_q.push_back({ovf_of(aa[15], bb[15], full[15]), full});
        end else begin
            a16 = 'x; b16 = 'x; c16 = 'x;
        end
    endtask

    // One clock: sample #1 after the edge; a valid cycle pops the scoreboard,
    // an idle cycle checks that the registers held their previous result.
    task automatic tick();
        logic p1, p8, p16;
        logic [2:0]  e1;
        logic [9:0]  e8;
        logic [17:0] e16;
        p1 = iv1; p8 = iv8; p16 = iv16;
        @(posedge clk);
        #1;
        chk("w1.out_valid", 32'(ov1), 32'(p1));
        chk("w8.out_valid", 32'(ov8), 32'(p8));
        chk("w16.out_valid", 32'(ov16), 32'(p16));
        if (p1) begin e1 = exp1_q.pop_front(); last1 = e1; end
        if (p8) begin e8 = exp8_q.pop_front(); last8 = e8; end
        if (p16) begin e16 = exp16_q.pop_front(); last16 = e16; end
        chk(p1 ? "w1.cout_sum" : "w1.hold", 32'({co1, s1}), 32'(last1[1:0]));
        chk(p8 ? "w8.cout_sum" : "w8.hold", 32'({co8, s8}), 32'(last8[8:0]));
        chk(p16 ? "w16.cout_sum" : "w16.hold", 32'({co16, s16}), 32'(last16[16:0]));
`ifdef FULL_ADDER_OVF_EN
        chk("w1.ovf", 32'(of1), 32'(last1[2]));
        chk("w8.ovf", 32'(of8), 32'(last8[9]));
        chk("w16.ovf", 32'(of16), 32'(last16[17]));
`endif
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".w1"}, 32'({ov1, co1, s1, of1}), 32'd0);
        chk({tag, ".w8"}, 32'({ov8, co8, s8, of8}), 32'd0);
        chk({tag, ".w16"}, 32'({ov16, co16, s16, of16}), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [2:0] bits;
        rst_n = 1'b0;
        last1 = '0; last8 = '0; last16 = '0;
        drv1(1'b0, 1'b0, 1'b0, 1'b0);
        drv8(1'b0, 8'h0, 8'h0, 1'b0);
        drv16(1'b0, 16'h0, 16'h0, 1'b0);
        #3;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset release: 1+1+1 on the 1-bit adder.
        drv1(1'b1, 1'b1, 1'b1, 1'b1);
        tick();

        // All eight 1-bit combinations back to back.
        for (int i = 0; i < 8; i++) begin
            bits = i[2:0];
            drv1(1'b1, bits[2], bits[1], bits[0]);
            tick();
        end
        drv1(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // 8-bit carry-out and signed-overflow corners.
        drv8(1'b1, 8'hFF, 8'h01, 1'b0);
        tick();
        drv8(1'b1, 8'h7F, 8'h01, 1'b0);
        tick();

        // Valid 1,0,1: result must hold through the gap while operands are X.
        drv8(1'b1, 8'h12, 8'h34, 1'b0);
        tick();
        drv8(1'b0, 8'h0, 8'h0, 1'b0);
        tick();
        tick();
        drv8(1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        drv8(1'b1, 8'h00, 8'h00, 1'b0);
        tick();
        drv8(1'b0, 8'h0, 8'h0, 1'b0);
        tick();

        // Asynchronous reset between edges while a result is pending.
        drv16(1'b1, 16'hBEEF, 16'h1234, 1'b1);
        tick();
        drv16(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        exp1_q.delete(); exp8_q.delete(); exp16_q.delete();
        last1 = '0; last8 = '0; last16 = '0;
        drv16(1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomised 16-bit stream, valid every cycle.
        for (int n = 0; n < 1000; n++) begin
            drv16(1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)));
            tick();
        end
        drv16(1'b0, 16'h0, 16'h0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
